// File: rtl/rfft_pkg.sv
// rfft_pkg
// Shared constants and types for the rfft sample memory slice.
//   ADDR_BIT    : row address width of one bank
//   DATA_BIT    : width of one real sample
//   MEM_HEIGHT  : rows per bank
//   NUM_BANK    : number of parallel banks feeding the butterfly
//   NUM_SAMPLES : samples collected before a compute phase may begin
//   state_t     : loader / compute state machine encoding
package rfft_pkg;

   localparam int ADDR_BIT    = 3;
   localparam int DATA_BIT    = 16;
   localparam int MEM_HEIGHT  = 1 << ADDR_BIT;
   localparam int NUM_BANK    = 4;
   localparam int NUM_SAMPLES = NUM_BANK * MEM_HEIGHT;

   typedef enum logic [1:0] {
      LOAD,
      FULL,
      COMPUTE
   } state_t;

endpackage

// File: rtl/rfft_sample_mem_if.sv
// rfft_sample_mem_if
// Bundles the serial loader handshake and the four-bank compute port.
//   in_valid/in_data/in_ready : serial sample stream into the loader
//   load_done/start/done/busy : phase control
//   addr_read/addr_write      : packed per-bank row addresses (bank i at [ADDR_BIT*i +: ADDR_BIT])
//   wr_en, wr0..wr3           : four-bank write-back
//   mem0..mem3                : registered per-bank read data
// master drives the stimulus side, slave is the memory itself.
interface rfft_sample_mem_if;
   import rfft_pkg::*;

   logic                           in_valid;
   logic [DATA_BIT-1:0]            in_data;
   logic                           in_ready;
   logic                           load_done;
   logic                           start;
   logic                           done;
   logic [ADDR_BIT*NUM_BANK-1:0]   addr_read;
   logic [ADDR_BIT*NUM_BANK-1:0]   addr_write;
   logic                           wr_en;
   logic [DATA_BIT-1:0]            wr0;
   logic [DATA_BIT-1:0]            wr1;
   logic [DATA_BIT-1:0]            wr2;
   logic [DATA_BIT-1:0]            wr3;
   logic [DATA_BIT-1:0]            mem0;
   logic [DATA_BIT-1:0]            mem1;
   logic [DATA_BIT-1:0]            mem2;
   logic [DATA_BIT-1:0]            mem3;
   logic                           busy;

   modport master (
      output in_valid, in_data, start, done, addr_read, addr_write,
             wr_en, wr0, wr1, wr2, wr3,
      input  in_ready, load_done, busy, mem0, mem1, mem2, mem3
   );

   modport slave (
      input  in_valid, in_data, start, done, addr_read, addr_write,
             wr_en, wr0, wr1, wr2, wr3,
      output in_ready, load_done, busy, mem0, mem1, mem2, mem3
   );

endinterface

// File: rtl/rfft_bank_ram.sv
// rfft_bank_ram
// One bank of sample storage: single clock, one registered read port and
// one write port. A read and write of the same row in one cycle returns
// the old contents; the new data is visible from the following cycle.
//   clk     : clock
//   rst     : synchronous active-high reset, clears only the read register
//   rd_en   : register a new read this cycle, otherwise rd_data holds
//   rd_addr : read row
//   rd_data : registered read data
//   wr_en   : write wr_data at wr_addr
//   wr_addr : write row
//   wr_data : write data
module rfft_bank_ram
   import rfft_pkg::*;
#(
   parameter int AW = ADDR_BIT,
   parameter int DW = DATA_BIT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data
);

   logic [DW-1:0] ram [2**AW];

   // Storage array is deliberately left without reset so it maps onto
   // plain RAM; a reset only restarts the loader, it never erases data.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         ram[wr_addr] <= wr_data;
      end
   end

   // Read register samples the array before this edge's write lands,
   // which is what gives read-before-write behaviour on a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= ram[rd_addr];
      end
   end

endmodule

// File: rtl/rfft_sample_mem.sv
// rfft_sample_mem
// Four-bank sample memory in front of the 4-point real FFT. Serial samples
// are interleaved across the banks (sample n -> bank n%4, row n/4); during
// compute every bank is read and optionally written in parallel.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (state, counter, read registers)
//   bus : rfft_sample_mem_if slave port (loader handshake, phase control,
//         packed addresses, write-back data, read data)
module rfft_sample_mem
   import rfft_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   rfft_sample_mem_if.slave    bus
);

   state_t              state;
   state_t              state_next;
   logic [4:0]          sample_cnt;
   logic                load_fire;
   logic                read_en;
   logic [DATA_BIT-1:0] wr_data_bank [NUM_BANK];
   logic [DATA_BIT-1:0] rd_data_bank [NUM_BANK];

   // State register for the load / full / compute cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. start and done are only looked at in their own
   // state, so a stray done while FULL cannot cancel a pending start.
   always_comb begin
      state_next = state;
      case (state)
         LOAD: begin
            if (load_fire && (sample_cnt == 5'(NUM_SAMPLES - 1))) begin
               state_next = FULL;
            end
         end
         FULL: begin
            if (bus.start) begin
               state_next = COMPUTE;
            end
         end
         COMPUTE: begin
            if (bus.done) begin
               state_next = LOAD;
            end
         end
         default: state_next = LOAD;
      endcase
   end

   // Status outputs decoded purely from the current state.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.load_done = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         LOAD:    bus.in_ready  = 1'b1;
         FULL:    bus.load_done = 1'b1;
         COMPUTE: bus.busy      = 1'b1;
         default: bus.in_ready  = 1'b0;
      endcase
   end

   assign load_fire = bus.in_valid & bus.in_ready;
   assign read_en   = (state == COMPUTE);

   // Sample counter. Wrapping 31 -> 0 on the last handshake means the
   // counter is already back at zero when compute hands control back.
   always_ff @(posedge clk) begin
      if (rst) begin
         sample_cnt <= '0;
      end else if (load_fire) begin
         if (sample_cnt == 5'(NUM_SAMPLES - 1)) begin
            sample_cnt <= '0;
         end else begin
            sample_cnt <= sample_cnt + 5'd1;
         end
      end
   end

   assign wr_data_bank[0] = bus.wr0;
   assign wr_data_bank[1] = bus.wr1;
   assign wr_data_bank[2] = bus.wr2;
   assign wr_data_bank[3] = bus.wr3;

   assign bus.mem0 = rd_data_bank[0];
   assign bus.mem1 = rd_data_bank[1];
   assign bus.mem2 = rd_data_bank[2];
   assign bus.mem3 = rd_data_bank[3];

   for (genvar i = 0; i < NUM_BANK; i++) begin : g_bank
      logic                bank_we;
      logic [ADDR_BIT-1:0] bank_waddr;
      logic [DATA_BIT-1:0] bank_wdata;

      // Write port steering: the loader owns the write port in LOAD (low
      // counter bits pick the bank, high bits the row), the compute
      // write-back owns it in COMPUTE. Reset suppresses any write so an
      // abort never lands a half-formed update.
      always_comb begin
         bank_we    = 1'b0;
         bank_waddr = bus.addr_write[ADDR_BIT*i +: ADDR_BIT];
         bank_wdata = wr_data_bank[i];
         if (state == LOAD) begin
            bank_we    = load_fire && (sample_cnt[1:0] == 2'(i)) && !rst;
            bank_waddr = sample_cnt[4:2];
            bank_wdata = bus.in_data;
         end else if (state == COMPUTE) begin
            bank_we    = bus.wr_en && !rst;
         end
      end

      rfft_bank_ram #(
         .AW (ADDR_BIT),
         .DW (DATA_BIT)
      ) u_ram (
         .clk     (clk),
         .rst     (rst),
         .rd_en   (read_en),
         .rd_addr (bus.addr_read[ADDR_BIT*i +: ADDR_BIT]),
         .rd_data (rd_data_bank[i]),
         .wr_en   (bank_we),
         .wr_addr (bank_waddr),
         .wr_data (bank_wdata)
      );
   end

endmodule

// File: doc/rfft_sample_mem.md
# rfft_sample_mem

Four-bank sample memory that sits directly upstream of `rfft_4pt`. It collects a serial stream of 32 real samples, interleaving them across four 8-deep banks. During compute it serves four parallel reads per cycle on `mem0..mem3` and accepts four parallel write-backs, using the same packed `addr_read`/`addr_write` buses that drive `rfft_4pt`. The loader, compute phase and reload form one state machine.

## Interface
Parameters:
- `ADDR_BIT`, 3, row address width per bank
- `DATA_BIT`, 16, sample width
- `MEM_HEIGHT`, 8, rows per bank (2^ADDR_BIT)
- `NUM_BANK`, 4, bank count (fixed; ports are per-bank)

Ports:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  serial sample valid
- `in_data`  in  DATA_BIT  serial sample
- `in_ready`  out  1  loader can accept a sample
- `load_done`  out  1  all 32 samples stored, awaiting `start`
- `start`  in  1  begin compute phase
- `done`  in  1  end compute phase, return to loading
- `addr_read`  in  ADDR_BIT*4  packed row addresses; bank i uses bits [ADDR_BIT*(i+1)-1 : ADDR_BIT*i]
- `addr_write`  in  ADDR_BIT*4  packed write addresses, same packing
- `wr_en`  in  1  write all four banks this cycle
- `wr0`, `wr1`, `wr2`, `wr3`  in  DATA_BIT each  write-back data for banks 0..3
- `mem0`, `mem1`, `mem2`, `mem3`  out  DATA_BIT each  registered read data for banks 0..3
- `busy`  out  1  high in COMPUTE

## Operation
- States: LOAD, FULL, COMPUTE.
- LOAD:
  - `in_ready`=1.
  - A handshake occurs when `in_valid` & `in_ready` are both high.
  - Each handshake stores `in_data` into bank n%4, row n/4, where n is the 5-bit sample counter. The counter then increments.
  - The handshake with n=31 stores the sample, clears the counter to 0 and moves to FULL.
  - `start`, `done` and `wr_en` are ignored.
- FULL:
  - `in_ready`=0 and `load_done`=1.
  - `in_valid` is ignored.
  - `start`=1 moves to COMPUTE.
- COMPUTE:
  - `busy`=1.
  - Every cycle, each bank i reads its row from `addr_read` into `mem{i}`.
  - If `wr_en`=1, each bank i writes `wr{i}` at its row from `addr_write`.
  - `done`=1 moves to LOAD. The counter is already 0. The read and write on the `done` cycle still take effect.
- Same-bank read and write to the same row in one cycle: the read returns the old contents (read-before-write). The new data is visible on the next read.
- `mem0..mem3` hold their value in LOAD and FULL.
- No arithmetic is performed. Data is stored and returned bit-exact.

## Timing
- Read latency is 1 cycle. The address presented at edge k appears on `mem{i}` after edge k.
- Write latency is 1 cycle. The location written at edge k is readable from edge k+1 onward.
- Loading takes exactly 32 handshake cycles. Loading at one sample per cycle, `load_done` rises the cycle after the 32nd handshake.
- The FULL→COMPUTE transition takes 1 cycle. The first read is registered on the edge after the edge that samples `start`.
- `start` and `done` are sampled only in their own states. Simultaneous `start` and `done` in FULL go to COMPUTE.
- Reset values:
  - state=LOAD, counter=0
  - `in_ready`=1, `load_done`=0, `busy`=0
  - `mem0..mem3`=0
  - Memory array contents are not reset.
- Reset mid-load or mid-compute aborts immediately. Partial contents remain, but the counter restarts at 0, so the next load overwrites from bank 0, row 0.

## Structure
- Shared package `rfft_pkg`:
  - `ADDR_BIT`, `DATA_BIT`, `MEM_HEIGHT`, `NUM_BANK`
  - state enum {LOAD, FULL, COMPUTE}
  - sample-count constant 32
- Sub-module `rfft_bank_ram`: one 8x16 single-clock RAM with 1 read port (registered, read-before-write) and 1 write port. It is instantiated four times.
- The top level holds the FSM, the counter and the address unpacking.

## Test plan
- Reset then load: after `rst`, stream samples 0..31 with values 100+n → `load_done` rises after the 32nd handshake and `in_ready`=0. In COMPUTE, `addr_read`=12'b001_001_001_001 reads `mem0..3` = 104, 105, 106, 107.
- Backpressure: in FULL, hold `in_valid`=1 with `in_data`=16'hDEAD for 5 cycles → the counter is unchanged and no bank contents change.
- Parallel read with mixed addresses: `addr_read`=12'b001_010_011_100 → the next cycle `mem0`=bank0[4]=116, `mem1`=bank1[3]=113, `mem2`=bank2[2]=110, `mem3`=bank3[1]=107.
- Write and read collision: `wr_en`=1, `addr_write`=`addr_read`=0, `wr0..3`=7, 8, 9, 10 → the same cycle returns the old values 100..103. Reading row 0 again returns 7, 8, 9, 10.
- `done` return and reload: assert `done` → `busy`=0 and `in_ready`=1 next cycle. Stream 32 new samples with values 200+n → reading row 0 returns 200..203.
- Reset mid-load: after 10 handshakes assert `rst` for 1 cycle, then load 32 samples with values 300+n → `load_done` rises after exactly 32 handshakes. Row 0 reads 300..303.
